// File: rtl/slide_engine.sv
// ----------------------------------------------------------------------------
// slide_engine
//
// Applies one sliding-tile move to an N x N board of tile exponents.
// A move is requested with start while idle. The engine captures the board,
// direction and score, then walks the board one line per cycle. In each line
// it compacts the tiles toward the target edge and merges equal neighbours.
// When the last line is done it publishes the new board, the new score and
// the moved/win flags, and pulses done for one cycle.
//
// Ports
//   clk        in   system clock, rising edge active
//   rst_n      in   asynchronous active-low reset
//   start      in   move request, only looked at while idle
//   dir        in   00 -> col N-1, 01 -> col 0, 10 -> row N-1, 11 -> row 0
//   cells_in   in   board, cell (r,c) at W-bit slice index r*N+c
//   points_in  in   score before the move
//   busy       out  high while a move is being processed (PROC and DONE)
//   done       out  one-cycle pulse when the result outputs are updated
//   cells_out  out  board after the last move, held between done pulses
//   points_out out  score after the last move, saturating
//   moved      out  the last move changed at least one cell
//   win        out  the last move produced a tile of exponent WIN_EXP
// ----------------------------------------------------------------------------
module slide_engine #(
    parameter int N          = 4,
    parameter int W          = 4,
    parameter int PW         = 13,
    parameter int SCORE_MODE = 0,
    parameter int WIN_EXP    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       dir,
    input  logic [N*N*W-1:0] cells_in,
    input  logic [PW-1:0]    points_in,
    output logic             busy,
    output logic             done,
    output logic [N*N*W-1:0] cells_out,
    output logic [PW-1:0]    points_out,
    output logic             moved,
    output logic             win
);

    localparam int BW = N * N * W;
    localparam int LW = $clog2(N);
    // Score arithmetic is done with headroom so saturation can be detected
    // before truncating back to PW bits.
    localparam int SW = PW + 16;
    localparam logic [W-1:0]  TILE_MAX   = '1;
    localparam logic [PW-1:0] POINTS_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        DONE
    } state_t;

    typedef logic [W-1:0] tile_t;

    state_t        state_q;
    logic [BW-1:0] board_q;
    logic [BW-1:0] board_d;
    logic [1:0]    dir_q;
    logic [PW-1:0] points_q;
    logic [PW-1:0] points_d;
    logic [LW-1:0] lineCnt_q;
    logic          movedAcc_q;
    logic          winAcc_q;

    logic          busy_q;
    logic          done_q;
    logic          moved_q;
    logic          win_q;
    logic [BW-1:0] cellsOut_q;
    logic [PW-1:0] pointsOut_q;

    tile_t         lineIn  [N];
    tile_t         lineOut [N];
    logic [SW-1:0] lineInc;
    logic [SW-1:0] pointsSum;
    logic          lineWin;
    logic          lineChanged;

    tile_t         pend;
    logic          havePend;
    int            outPos;

    // Maps (direction, line number, position along the line) to a flat cell
    // index. Position 0 is always the cell on the target edge, so the merge
    // logic below can work on every line the same way regardless of dir.
    function automatic int cellIndex(input logic [1:0] d, input int lineIdx, input int pos);
        int r;
        int c;
        r = 0;
        c = 0;
        case (d)
            2'b00: begin
                r = lineIdx;
                c = N - 1 - pos;
            end
            2'b01: begin
                r = lineIdx;
                c = pos;
            end
            2'b10: begin
                r = N - 1 - pos;
                c = lineIdx;
            end
            default: begin
                r = pos;
                c = lineIdx;
            end
        endcase
        return r * N + c;
    endfunction

    // Pull the line currently being worked on out of the working board,
    // ordered from the target edge outward.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lineIn[i] = board_q[cellIndex(dir_q, int'(lineCnt_q), i) * W +: W];
        end
    end

    // Single-pass compact-and-merge. A non-empty tile is held as "pending"
    // until the next non-empty tile is seen; if the two are equal (and not at
    // the top exponent) they merge and the pending slot is emptied, which is
    // what stops a freshly merged tile from merging again in this move.
    always_comb begin
        lineOut  = '{default: '0};
        lineInc  = '0;
        lineWin  = 1'b0;
        pend     = '0;
        havePend = 1'b0;
        outPos   = 0;
        for (int i = 0; i < N; i++) begin
            if (lineIn[i] != '0) begin
                if (havePend && (lineIn[i] == pend) && (pend != TILE_MAX)) begin
                    lineOut[outPos] = pend + 1'b1;
                    outPos          = outPos + 1;
                    havePend        = 1'b0;
                    if (SCORE_MODE == 1) begin
                        lineInc = lineInc + SW'(pend) + SW'(1);
                    end else begin
                        lineInc = lineInc + SW'(1);
                    end
                    if ((int'(pend) + 1) == WIN_EXP) begin
                        lineWin = 1'b1;
                    end
                end else begin
                    if (havePend) begin
                        lineOut[outPos] = pend;
                        outPos          = outPos + 1;
                    end
                    pend     = lineIn[i];
                    havePend = 1'b1;
                end
            end
        end
        if (havePend) begin
            lineOut[outPos] = pend;
        end
    end

    // Write the processed line back into a copy of the working board, note
    // whether it differs from what was there, and add this line's score with
    // saturation so the running score never wraps.
    always_comb begin
        board_d     = board_q;
        lineChanged = 1'b0;
        for (int i = 0; i < N; i++) begin
            board_d[cellIndex(dir_q, int'(lineCnt_q), i) * W +: W] = lineOut[i];
            if (lineOut[i] != lineIn[i]) begin
                lineChanged = 1'b1;
            end
        end
        pointsSum = SW'(points_q) + lineInc;
        if (pointsSum > SW'(POINTS_MAX)) begin
            points_d = POINTS_MAX;
        end else begin
            points_d = pointsSum[PW-1:0];
        end
    end

    // Control FSM with all outputs registered. The result registers are
    // loaded on the same edge that enters DONE, so done and the new results
    // appear together, N cycles after the edge that accepts start. Inputs are
    // only sampled in IDLE, which is what makes them don't-care while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            board_q     <= '0;
            dir_q       <= '0;
            points_q    <= '0;
            lineCnt_q   <= '0;
            movedAcc_q  <= 1'b0;
            winAcc_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            moved_q     <= 1'b0;
            win_q       <= 1'b0;
            cellsOut_q  <= '0;
            pointsOut_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        board_q    <= cells_in;
                        dir_q      <= dir;
                        points_q   <= points_in;
                        lineCnt_q  <= '0;
                        movedAcc_q <= 1'b0;
                        winAcc_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= PROC;
                    end
                end
                PROC: begin
                    board_q    <= board_d;
                    points_q   <= points_d;
                    movedAcc_q <= movedAcc_q | lineChanged;
                    winAcc_q   <= winAcc_q | lineWin;
                    if (lineCnt_q == LW'(N - 1)) begin
                        cellsOut_q  <= board_d;
                        pointsOut_q <= points_d;
                        moved_q     <= movedAcc_q | lineChanged;
                        win_q       <= winAcc_q | lineWin;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        lineCnt_q <= lineCnt_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cells_out  = cellsOut_q;
    assign points_out = pointsOut_q;
    assign moved      = moved_q;
    assign win        = win_q;

endmodule

// File: tb/tb_slide_engine.sv
// ----------------------------------------------------------------------------
// tb_slide_engine
//
// Bench for slide_engine with default parameters. Directed vectors from a
// table, a reset-during-move sequence, then random boards compared with a
// queue-based model of the sliding rules.
// ----------------------------------------------------------------------------
module tb_slide_engine;

    localparam int N          = 4;
    localparam int W          = 4;
    localparam int PW         = 13;
    localparam int SCORE_MODE = 0;
    localparam int WIN_EXP    = 11;
    localparam int BW         = N * N * W;
    localparam int TMAX       = (1 << W) - 1;
    localparam int PMAX       = (1 << PW) - 1;
    localparam int MAXWAIT    = 20;
    localparam int NVEC       = 10;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    dir;
    logic [BW-1:0] cells_in;
    logic [PW-1:0] points_in;
    logic          busy;
    logic          done;
    logic [BW-1:0] cells_out;
    logic [PW-1:0] points_out;
    logic          moved;
    logic          win;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct packed {
        logic [BW-1:0] cells;
        logic [PW-1:0] points;
        logic          moved;
        logic          win;
    } result_t;

    typedef struct packed {
        logic [BW-1:0] cells;
        logic [1:0]    dir;
        logic [PW-1:0] points;
        result_t       exp;
    } vec_t;

    vec_t          vecs [NVEC];
    logic [BW-1:0] b;
    logic [BW-1:0] e;
    int            lat;
    bit            busyHeld;
    bit            sawDone;
    logic [BW-1:0] midCells;
    logic [BW-1:0] prevCells;
    logic [BW-1:0] rndCells;
    logic [1:0]    rndDir;
    logic [PW-1:0] rndPts;
    result_t       rndExp;

    slide_engine #(
        .N(N),
        .W(W),
        .PW(PW),
        .SCORE_MODE(SCORE_MODE),
        .WIN_EXP(WIN_EXP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dir(dir),
        .cells_in(cells_in),
        .points_in(points_in),
        .busy(busy),
        .done(done),
        .cells_out(cells_out),
        .points_out(points_out),
        .moved(moved),
        .win(win)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [BW-1:0] cellSet(input logic [BW-1:0] bd, input int r, input int c, input int v);
        logic [BW-1:0] t;
        t = bd;
        t[(r * N + c) * W +: W] = W'(v);
        return t;
    endfunction

    function automatic vec_t mkVec(input logic [BW-1:0] c, input logic [1:0] d, input int p,
                                   input logic [BW-1:0] ec, input int ep, input bit em, input bit ew);
        vec_t v;
        v.cells      = c;
        v.dir        = d;
        v.points     = PW'(p);
        v.exp.cells  = ec;
        v.exp.points = PW'(ep);
        v.exp.moved  = em;
        v.exp.win    = ew;
        return v;
    endfunction

    // Row/column of the cell at distance pos from the target edge.
    function automatic void rcOf(input logic [1:0] d, input int ln, input int pos, output int r, output int c);
        case (d)
            2'b00:   begin r = ln;          c = N - 1 - pos; end
            2'b01:   begin r = ln;          c = pos;         end
            2'b10:   begin r = N - 1 - pos; c = ln;          end
            default: begin r = pos;         c = ln;          end
        endcase
    endfunction

    // Reference move: gather the non-empty tiles of each line into a queue,
    // then walk the queue merging equal pairs, then pad with empties.
    function automatic result_t modelMove(input logic [BW-1:0] cells, input logic [1:0] d, input logic [PW-1:0] pts);
        result_t       res;
        int            grid [N][N];
        int            tiles [$];
        int            merged [$];
        int            r;
        int            c;
        int            k;
        int            score;
        bit            anyWin;
        logic [BW-1:0] nb;
        for (int rr = 0; rr < N; rr++) begin
            for (int cc = 0; cc < N; cc++) begin
                grid[rr][cc] = int'(cells[(rr * N + cc) * W +: W]);
            end
        end
        score  = int'(pts);
        anyWin = 1'b0;
        for (int ln = 0; ln < N; ln++) begin
            tiles.delete();
            merged.delete();
            for (int p = 0; p < N; p++) begin
                rcOf(d, ln, p, r, c);
                if (grid[r][c] != 0) tiles.push_back(grid[r][c]);
            end
            k = 0;
            while (k < tiles.size()) begin
                if ((k + 1 < tiles.size()) && (tiles[k] == tiles[k + 1]) && (tiles[k] != TMAX)) begin
                    merged.push_back(tiles[k] + 1);
                    score += (SCORE_MODE == 1) ? tiles[k] + 1 : 1;
                    if (tiles[k] + 1 == WIN_EXP) anyWin = 1'b1;
                    k += 2;
                end else begin
                    merged.push_back(tiles[k]);
                    k += 1;
                end
            end
            for (int p = 0; p < N; p++) begin
                rcOf(d, ln, p, r, c);
                grid[r][c] = (p < merged.size()) ? merged[p] : 0;
            end
        end
        nb = '0;
        for (int rr = 0; rr < N; rr++) begin
            for (int cc = 0; cc < N; cc++) begin
                nb[(rr * N + cc) * W +: W] = W'(grid[rr][cc]);
            end
        end
        res.cells  = nb;
        res.points = (score > PMAX) ? PW'(PMAX) : PW'(score);
        res.moved  = (nb != cells);
        res.win    = anyWin;
        return res;
    endfunction

    function automatic int randTile();
        int r;
        r = int'($urandom_range(0, 11));
        if (r < 4) return 0;
        if (r < 9) return r - 3;
        if (r < 11) return 10;
        return TMAX;
    endfunction

    task automatic checkOutput(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Presents a move (called #1 after a rising edge) and returns once done is
    // seen or the wait budget runs out. With scribble set, the inputs are
    // thrashed while the engine is busy.
    task automatic applyStimulus(input logic [BW-1:0] c, input logic [1:0] d, input logic [PW-1:0] p,
                                 input bit scribble, output int latency, output bit busyAll,
                                 output logic [BW-1:0] mid);
        cells_in  = c;
        dir       = d;
        points_in = p;
        start     = 1'b1;
        latency   = 0;
        busyAll   = 1'b1;
        mid       = '0;
        while (latency < MAXWAIT) begin
            @(posedge clk);
            #1;
            latency++;
            if (latency == 2) mid = cells_out;
            if (!busy) busyAll = 1'b0;
            if (done) break;
            if (scribble) begin
                start     = 1'($urandom_range(0, 1));
                cells_in  = BW'({$urandom(), $urandom()});
                dir       = 2'($urandom_range(0, 3));
                points_in = PW'($urandom());
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic checkMove(input string tag, input result_t exp, input int latency, input bit busyAll,
                             input logic [BW-1:0] mid, input logic [BW-1:0] prev);
        checkOutput({tag, " latency"}, BW'(latency), BW'(N + 1));
        checkOutput({tag, " busy"}, BW'(busyAll), BW'(1));
        checkOutput({tag, " hold"}, mid, prev);
        checkOutput({tag, " cells"}, cells_out, exp.cells);
        checkOutput({tag, " points"}, BW'(points_out), BW'(exp.points));
        checkOutput({tag, " moved/win"}, BW'({moved, win}), BW'({exp.moved, exp.win}));
        @(posedge clk);
        #1;
        checkOutput({tag, " pulse"}, BW'({done, busy}), BW'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        dir       = 2'b00;
        cells_in  = '0;
        points_in = '0;

        // Row 0: 1,1,0,0 toward col 3
        b = cellSet('0, 0, 0, 1); b = cellSet(b, 0, 1, 1);
        e = cellSet('0, 0, 3, 2);
        vecs[0] = mkVec(b, 2'b00, 0, e, 1, 1'b1, 1'b0);
        // Row 0: 1,1,1,1 toward col 0
        b = cellSet('0, 0, 0, 1); b = cellSet(b, 0, 1, 1); b = cellSet(b, 0, 2, 1); b = cellSet(b, 0, 3, 1);
        e = cellSet('0, 0, 0, 2); e = cellSet(e, 0, 1, 2);
        vecs[1] = mkVec(b, 2'b01, 5, e, 7, 1'b1, 1'b0);
        // Column 0: 10,10,0,0 toward row 3
        b = cellSet('0, 0, 0, 10); b = cellSet(b, 1, 0, 10);
        e = cellSet('0, 3, 0, 11);
        vecs[2] = mkVec(b, 2'b10, 0, e, 1, 1'b1, 1'b1);
        // Packed board, no equal neighbours
        b = '0;
        for (int i = 0; i < N * N; i++) b[i * W +: W] = W'((i % 15) + 1);
        vecs[3] = mkVec(b, 2'b10, 100, b, 100, 1'b0, 1'b0);
        // Score saturation
        b = cellSet('0, 0, 0, 1); b = cellSet(b, 0, 1, 1);
        e = cellSet('0, 0, 3, 2);
        vecs[4] = mkVec(b, 2'b00, PMAX, e, PMAX, 1'b1, 1'b0);
        // Top exponent never merges
        b = cellSet('0, 0, 0, 15); b = cellSet(b, 0, 1, 15);
        e = cellSet('0, 0, 2, 15); e = cellSet(e, 0, 3, 15);
        vecs[5] = mkVec(b, 2'b00, 50, e, 50, 1'b1, 1'b0);
        // 2,2,2,2 -> 3,3 from the edge
        b = cellSet('0, 0, 0, 2); b = cellSet(b, 0, 1, 2); b = cellSet(b, 0, 2, 2); b = cellSet(b, 0, 3, 2);
        e = cellSet('0, 0, 3, 3); e = cellSet(e, 0, 2, 3);
        vecs[6] = mkVec(b, 2'b00, 0, e, 2, 1'b1, 1'b0);
        // Row 1: 1,0,1,2 toward col 0 -> 2,2,0,0 (new tile does not merge again)
        b = cellSet('0, 1, 0, 1); b = cellSet(b, 1, 2, 1); b = cellSet(b, 1, 3, 2);
        e = cellSet('0, 1, 0, 2); e = cellSet(e, 1, 1, 2);
        vecs[7] = mkVec(b, 2'b01, 7, e, 8, 1'b1, 1'b0);
        // Column 2: 0,3,3,3 toward row 0 -> 4,3,0,0
        b = cellSet('0, 1, 2, 3); b = cellSet(b, 2, 2, 3); b = cellSet(b, 3, 2, 3);
        e = cellSet('0, 0, 2, 4); e = cellSet(e, 1, 2, 3);
        vecs[8] = mkVec(b, 2'b11, 20, e, 21, 1'b1, 1'b0);
        // Tiles already against the edge
        b = cellSet('0, 2, 0, 4); b = cellSet(b, 2, 1, 5);
        vecs[9] = mkVec(b, 2'b01, 9, b, 9, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        checkOutput("reset cells", cells_out, '0);
        checkOutput("reset flags", BW'({busy, done, moved, win}), '0);
        checkOutput("reset points", BW'(points_out), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle flags", BW'({busy, done, moved, win}), '0);

        prevCells = '0;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].cells, vecs[i].dir, vecs[i].points, (i % 2) == 1, lat, busyHeld, midCells);
            checkMove($sformatf("vec%0d", i), vecs[i].exp, lat, busyHeld, midCells, prevCells);
            prevCells = vecs[i].exp.cells;
        end

        // Reset during the second PROC cycle
        cells_in  = vecs[0].cells;
        dir       = vecs[0].dir;
        points_in = vecs[0].points;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort flags", BW'({busy, done, moved, win}), '0);
        checkOutput("abort cells", cells_out, '0);
        checkOutput("abort points", BW'(points_out), '0);
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < N + 3; k++) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("abort no done", BW'(sawDone), '0);
        checkOutput("abort idle", BW'({busy, moved, win}), '0);
        prevCells = '0;
        applyStimulus(vecs[0].cells, vecs[0].dir, vecs[0].points, 1'b0, lat, busyHeld, midCells);
        checkMove("after abort", vecs[0].exp, lat, busyHeld, midCells, prevCells);
        prevCells = vecs[0].exp.cells;

        for (int t = 0; t < 40; t++) begin
            rndCells = '0;
            for (int cc = 0; cc < N * N; cc++) rndCells[cc * W +: W] = W'(randTile());
            rndDir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                rndPts = PW'(PMAX - int'($urandom_range(0, 3)));
            end else begin
                rndPts = PW'($urandom_range(0, PMAX));
            end
            rndExp = modelMove(rndCells, rndDir, rndPts);
            applyStimulus(rndCells, rndDir, rndPts, t[0], lat, busyHeld, midCells);
            checkMove($sformatf("rnd%0d", t), rndExp, lat, busyHeld, midCells, prevCells);
            prevCells = rndExp.cells;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
